ca_row_engine: RTL and testbench
================================

Name: ca_row_engine

Overview:
Parametrised 1D elementary cellular-automaton generator. It evolves a WIDTH-cell row under a runtime-selectable 8-bit rule and streams each generation into a ROWS-deep row-addressed framebuffer through a ready/valid write port. It is driven by a slow step strobe from the prescaler and sits between the prescaler and the dual-port image memory read by the VGA pipeline. It extends the fixed-width, fixed-rule engine with:
- configurable boundary mode
- seed loading
- single-step control
- write backpressure
- overrun detection

Parameters:
WIDTH, 80, cells per row; cell WIDTH-1 is leftmost.
ROWS, 60, framebuffer depth in rows.
RW, 7, row-address width; must satisfy 2**RW >= ROWS.
BOUNDARY, 0, 0 = cells outside the row read as 0; 1 = toroidal wrap (left of WIDTH-1 is cell 0, right of cell 0 is WIDTH-1).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
tick  in  1  one-cycle step strobe from prescaler
run  in  1  level; 1 = advance on every tick
step  in  1  one-cycle strobe; advance one generation regardless of run
load  in  1  one-cycle strobe; latch seed and restart
seed  in  WIDTH  initial generation
rule  in  8  Wolfram rule number, sampled at compute time
wr_en  out  1  write valid
wr_row  out  RW  row address of wr_data
wr_data  out  WIDTH  generation being written
wr_ready  in  1  framebuffer accepts the write this cycle
gen_count  out  16  generations since last load, wraps at 65535 -> 0
frame_done  out  1  one-cycle pulse when row ROWS-1 is accepted
top_row  out  RW  oldest displayed row
overrun  out  1  sticky; an advance request was dropped
busy  out  1  1 while in WRITE

Behaviour:
- Reset (async): state IDLE; cur = 0, seed_q = 0, wr_en = 0, wr_row = 0, gen_count = 0, frame_done = 0, top_row = 0, overrun = 0, load_pend = 0.
- Advance request: adv = (tick & run) | step.
- Next-state rule: new[i] = rule[{L,C,R}].
  - L = cur[i+1], C = cur[i], R = cur[i-1].
  - Out-of-range neighbours follow BOUNDARY.
  - All cells update in parallel, combinationally from cur.
- IDLE:
  - load -> seed_q <= seed, cur <= seed, wr_row <= 0, gen_count <= 0, overrun <= 0, top_row <= 0; go to WRITE.
  - adv is ignored in IDLE.
- WRITE:
  - wr_en = 1 and wr_data = cur, both registered.
  - wr_row and wr_data hold stable until wr_en & wr_ready.
  - On acceptance: wr_row <= (wr_row == ROWS-1) ? 0 : wr_row+1, then go to WAIT.
  - frame_done pulses the cycle after acceptance of row ROWS-1.
  - adv arriving in WRITE is dropped and sets overrun.
  - load arriving in WRITE sets load_pend.
- WAIT, priority order:
  - load or load_pend -> same action as load in IDLE, clear load_pend, go to WRITE.
  - else adv -> cur <= next(cur), gen_count++, go to WRITE.
  - Latency: adv to wr_en = 1 cycle.
- Simultaneous load and adv in WAIT: load wins; adv is discarded without setting overrun.
- wr_ready held high: one row is written per advance, with wr_en high for exactly 1 cycle.
- rule changes take effect at the next computed generation; the row already written is unaffected.

Optional Feature:
- Macro: CA_SCROLL_EN.
- Defined:
  - After the first frame_done, evolution continues and writes wrap over the oldest row.
  - top_row = wr_row after each acceptance once the first frame is filled; otherwise 0.
  - The display reads starting at top_row, giving upward scroll.
- Undefined:
  - top_row is tied to 0.
  - After frame_done, the next advance in WAIT reloads cur <= seed_q and gen_count <= 0 instead of computing, and writes it to row 0.
  - The image restarts from the seed each frame.

Test Plan:
1. Reset mid-WRITE (wr_ready=0): assert rst -> wr_en=0, wr_row=0, gen_count=0 immediately, without waiting for a clock edge.
2. WIDTH=8, BOUNDARY=0, rule=30, load seed 8'b00010000, then step -> writes 00010000 to row 0 and 00111000 to row 1; gen_count=1.
3. rule=90, seed 8'b00000001, one step:
   - BOUNDARY=0 -> 00000010.
   - BOUNDARY=1 -> 10000010.
4. Backpressure: wr_ready=0 for 5 cycles while tick and run are high -> wr_data and wr_row stable, overrun=1, exactly one row written once wr_ready=1; a following load clears overrun.
5. ROWS=4, run=1, wr_ready=1, 5 ticks after load:
   - Without CA_SCROLL_EN -> frame_done after row 3; the 4th tick rewrites the seed to row 0.
   - With CA_SCROLL_EN -> gen 4 is written to row 0 and top_row=1.
6. load and tick in the same WAIT cycle -> seed is written to row 0, gen_count=0, overrun stays 0.

Source files
------------

// File: rtl/ca_row_engine_if.sv
// ca_row_engine_if -- framebuffer row-write port.
//
// Carries one generation per transfer from the CA engine to the row-addressed
// image memory. A write completes on a cycle where wr_en and wr_ready are
// both high; until then the master holds wr_row and wr_data steady.
//
// Signals:
//   wr_en     master -> slave  write valid
//   wr_row    master -> slave  row address (RW bits)
//   wr_data   master -> slave  generation bits (WIDTH bits, bit WIDTH-1 leftmost)
//   wr_ready  slave  -> master memory accepts the write this cycle
interface ca_row_engine_if #(
  parameter int WIDTH = 80,
  parameter int RW    = 7
);
  logic             wr_en;
  logic [RW-1:0]    wr_row;
  logic [WIDTH-1:0] wr_data;
  logic             wr_ready;

  modport master (output wr_en, output wr_row, output wr_data, input  wr_ready);
  modport slave  (input  wr_en, input  wr_row, input  wr_data, output wr_ready);
endinterface

// File: rtl/ca_row_engine.sv
// ca_row_engine -- 1D elementary cellular-automaton row generator.
//
// Evolves a WIDTH-cell row under a runtime 8-bit Wolfram rule and writes each
// generation into a ROWS-deep framebuffer through a ready/valid port.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   tick_i         one-cycle step strobe from the prescaler
//   run_i          level; advance on every tick while high
//   step_i         one-cycle strobe; advance once regardless of run_i
//   load_i         one-cycle strobe; latch seed_i and restart at row 0
//   seed_i         initial generation
//   rule_i         Wolfram rule, sampled when a generation is computed
//   wr_if          framebuffer write port (master side)
//   gen_count_o    generations since last load (16-bit, wraps)
//   frame_done_o   one-cycle pulse after row ROWS-1 is accepted
//   top_row_o      oldest displayed row
//   overrun_o      sticky; an advance request arrived while writing
//   busy_o         high while a row write is outstanding
//
// Build option: define CA_SCROLL_EN to keep evolving after the first frame and
// scroll the display via top_row_o. Without it the image restarts from the
// seed after every completed frame and top_row_o stays 0.
module ca_row_engine #(
  parameter int WIDTH    = 80,
  parameter int ROWS     = 60,
  parameter int RW       = 7,
  parameter int BOUNDARY = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic                run_i,
  input  logic                step_i,
  input  logic                load_i,
  input  logic [WIDTH-1:0]    seed_i,
  input  logic [7:0]          rule_i,
  ca_row_engine_if.master     wr_if,
  output logic [15:0]         gen_count_o,
  output logic                frame_done_o,
  output logic [RW-1:0]       top_row_o,
  output logic                overrun_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] seed_q, seed_d;
  logic             wr_en_q, wr_en_d;
  logic [RW-1:0]    wr_row_q, wr_row_d;
  logic [15:0]      gen_count_q, gen_count_d;
  logic             frame_done_q, frame_done_d;
  logic [RW-1:0]    top_row_q, top_row_d;
  logic             overrun_q, overrun_d;
  logic             load_pend_q, load_pend_d;
  // Set once row ROWS-1 has been accepted since the last (re)start.
  logic             filled_q, filled_d;

  logic             adv_s;
  logic             last_row_s;
  logic [RW-1:0]    row_inc_s;

  // One generation step. ext[i+1] holds cell i; ext[0] and ext[WIDTH+1] are
  // the neighbours just outside the right and left edges.
  function automatic logic [WIDTH-1:0] next_gen(input logic [WIDTH-1:0] c,
                                                input logic [7:0]       r);
    logic [WIDTH+1:0] ext;
    logic [WIDTH-1:0] res;
    ext[WIDTH:1] = c;
    if (BOUNDARY == 1) begin
      ext[0]       = c[WIDTH-1];
      ext[WIDTH+1] = c[0];
    end else begin
      ext[0]       = 1'b0;
      ext[WIDTH+1] = 1'b0;
    end
    for (int i = 0; i < WIDTH; i++) begin
      res[i] = r[{ext[i+2], ext[i+1], ext[i]}];
    end
    return res;
  endfunction

  assign adv_s      = (tick_i & run_i) | step_i;
  assign last_row_s = (wr_row_q == RW'(ROWS - 1));
  assign row_inc_s  = last_row_s ? {RW{1'b0}} : (wr_row_q + {{(RW-1){1'b0}}, 1'b1});

  // Next-state and datapath update for the write/advance sequencer.
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    seed_d       = seed_q;
    wr_en_d      = wr_en_q;
    wr_row_d     = wr_row_q;
    gen_count_d  = gen_count_q;
    frame_done_d = 1'b0;
    top_row_d    = top_row_q;
    overrun_d    = overrun_q;
    load_pend_d  = load_pend_q;
    filled_d     = filled_q;

    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          seed_d      = seed_i;
          cur_d       = seed_i;
          wr_row_d    = {RW{1'b0}};
          gen_count_d = 16'd0;
          overrun_d   = 1'b0;
          top_row_d   = {RW{1'b0}};
          load_pend_d = 1'b0;
          filled_d    = 1'b0;
          wr_en_d     = 1'b1;
          state_d     = ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WRITE: begin
        if (adv_s) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (load_i) begin
          load_pend_d = 1'b1;
        end else begin
          load_pend_d = load_pend_q;
        end
        if (wr_if.wr_ready) begin
          wr_en_d      = 1'b0;
          wr_row_d     = row_inc_s;
          frame_done_d = last_row_s;
          filled_d     = filled_q | last_row_s;
`ifdef CA_SCROLL_EN
          // Once a full frame exists the oldest row is the next one to be overwritten.
          if (filled_q || last_row_s) begin
            top_row_d = row_inc_s;
          end else begin
            top_row_d = {RW{1'b0}};
          end
`endif
          state_d = ST_WAIT;
        end else begin
          state_d = ST_WRITE;
        end
      end

      ST_WAIT: begin
        if (load_i || load_pend_q) begin
          // Load wins over a simultaneous advance, which is silently discarded.
          seed_d      = seed_i;
          cur_d       = seed_i;
          wr_row_d    = {RW{1'b0}};
          gen_count_d = 16'd0;
          overrun_d   = 1'b0;
          top_row_d   = {RW{1'b0}};
          load_pend_d = 1'b0;
          filled_d    = 1'b0;
          wr_en_d     = 1'b1;
          state_d     = ST_WRITE;
          // A pending load replays the seed captured now, so keep seed_i current when load_pend_q fires.
        end else if (adv_s) begin
`ifdef CA_SCROLL_EN
          cur_d       = next_gen(cur_q, rule_i);
          gen_count_d = gen_count_q + 16'd1;
`else
          // After a completed frame, restart the picture from the stored seed.
          if (filled_q) begin
            cur_d       = seed_q;
            gen_count_d = 16'd0;
            filled_d    = 1'b0;
          end else begin
            cur_d       = next_gen(cur_q, rule_i);
            gen_count_d = gen_count_q + 16'd1;
          end
`endif
          wr_en_d = 1'b1;
          state_d = ST_WRITE;
        end else begin
          state_d = ST_WAIT;
        end
      end

      default: begin
        wr_en_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cur_q        <= {WIDTH{1'b0}};
      seed_q       <= {WIDTH{1'b0}};
      wr_en_q      <= 1'b0;
      wr_row_q     <= {RW{1'b0}};
      gen_count_q  <= 16'd0;
      frame_done_q <= 1'b0;
      top_row_q    <= {RW{1'b0}};
      overrun_q    <= 1'b0;
      load_pend_q  <= 1'b0;
      filled_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      seed_q       <= seed_d;
      wr_en_q      <= wr_en_d;
      wr_row_q     <= wr_row_d;
      gen_count_q  <= gen_count_d;
      frame_done_q <= frame_done_d;
      top_row_q    <= top_row_d;
      overrun_q    <= overrun_d;
      load_pend_q  <= load_pend_d;
      filled_q     <= filled_d;
    end
  end

  // cur_q is only updated when entering WRITE, so it doubles as the held write data.
  assign wr_if.wr_en   = wr_en_q;
  assign wr_if.wr_row  = wr_row_q;
  assign wr_if.wr_data = cur_q;
  assign gen_count_o   = gen_count_q;
  assign frame_done_o  = frame_done_q;
  assign top_row_o     = top_row_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = (state_q == ST_WRITE);

endmodule

// File: tb/tb_ca_row_engine.sv
// tb_ca_row_engine -- directed self-checking bench for ca_row_engine.
// Two instances (WIDTH=8, ROWS=4): dut0 with zero boundary, dut1 toroidal.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ca_row_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0, run = 1'b0, step = 1'b0, load = 1'b0, ready = 1'b1;
  logic [7:0] seed = 8'h00, rule = 8'h00;

  logic [15:0] gc0, gc1;
  logic        fd0, fd1, ov0, ov1, busy0, busy1;
  logic [1:0]  top0, top1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ca_row_engine_if #(.WIDTH(8), .RW(2)) bus0 ();
  ca_row_engine_if #(.WIDTH(8), .RW(2)) bus1 ();
  assign bus0.wr_ready = ready;
  assign bus1.wr_ready = ready;

  ca_row_engine #(.WIDTH(8), .ROWS(4), .RW(2), .BOUNDARY(0)) dut0 (
    .clk(clk), .rst(rst), .tick_i(tick), .run_i(run), .step_i(step),
    .load_i(load), .seed_i(seed), .rule_i(rule), .wr_if(bus0.master),
    .gen_count_o(gc0), .frame_done_o(fd0), .top_row_o(top0),
    .overrun_o(ov0), .busy_o(busy0)
  );

  ca_row_engine #(.WIDTH(8), .ROWS(4), .RW(2), .BOUNDARY(1)) dut1 (
    .clk(clk), .rst(rst), .tick_i(tick), .run_i(run), .step_i(step),
    .load_i(load), .seed_i(seed), .rule_i(rule), .wr_if(bus1.master),
    .gen_count_o(gc1), .frame_done_o(fd1), .top_row_o(top1),
    .overrun_o(ov1), .busy_o(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Expected writes for five ticks after loading 8'h10 under rule 30 (zero boundary).
`ifdef CA_SCROLL_EN
  logic [7:0]  exp_data [5] = '{8'h38, 8'h64, 8'hDE, 8'h91, 8'hFB};
  logic [1:0]  exp_row  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [15:0] exp_gen  [5] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5};
  logic [1:0]  exp_top  [5] = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
`else
  logic [7:0]  exp_data [5] = '{8'h38, 8'h64, 8'hDE, 8'h10, 8'h38};
  logic [1:0]  exp_row  [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [15:0] exp_gen  [5] = '{16'd1, 16'd2, 16'd3, 16'd0, 16'd1};
  logic [1:0]  exp_top  [5] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
  logic        exp_fd   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    // Reset state
    repeat (2) cyc();
    chk("rst_wr_en",   {31'd0, bus0.wr_en}, 32'd0);
    chk("rst_wr_row",  {30'd0, bus0.wr_row}, 32'd0);
    chk("rst_gen",     {16'd0, gc0}, 32'd0);
    chk("rst_overrun", {31'd0, ov0}, 32'd0);
    chk("rst_top",     {30'd0, top0}, 32'd0);
    chk("rst_busy",    {31'd0, busy0}, 32'd0);
    rst = 1'b0;
    cyc();

    // Advance in IDLE is ignored
    step = 1'b1; cyc(); step = 1'b0;
    chk("idle_step_ignored", {31'd0, bus0.wr_en}, 32'd0);

    // Rule 30 from a single cell
    rule = 8'd30; seed = 8'b0001_0000; load = 1'b1; cyc(); load = 1'b0;
    chk("r30_load_en",   {31'd0, bus0.wr_en}, 32'd1);
    chk("r30_load_data", {24'd0, bus0.wr_data}, 32'h10);
    chk("r30_load_row",  {30'd0, bus0.wr_row}, 32'd0);
    cyc();
    chk("r30_one_cycle_en", {31'd0, bus0.wr_en}, 32'd0);
    step = 1'b1; cyc(); step = 1'b0;
    chk("r30_step_en",   {31'd0, bus0.wr_en}, 32'd1);
    chk("r30_step_data", {24'd0, bus0.wr_data}, 32'h38);
    chk("r30_step_row",  {30'd0, bus0.wr_row}, 32'd1);
    chk("r30_step_gen",  {16'd0, gc0}, 32'd1);
    cyc();
    chk("r30_step_done", {31'd0, bus0.wr_en}, 32'd0);

    // Rule 90 boundary handling
    rule = 8'd90; seed = 8'b0000_0001; load = 1'b1; cyc(); load = 1'b0;
    chk("r90_load_row", {30'd0, bus0.wr_row}, 32'd0);
    cyc();
    step = 1'b1; cyc(); step = 1'b0;
    chk("r90_zero_bnd", {24'd0, bus0.wr_data}, 32'h02);
    chk("r90_wrap_bnd", {24'd0, bus1.wr_data}, 32'h82);
    cyc();

    // Reset asserted mid-WRITE, checked before any clock edge
    ready = 1'b0;
    step = 1'b1; cyc(); step = 1'b0;
    chk("mid_pre_en",   {31'd0, bus0.wr_en}, 32'd1);
    chk("mid_pre_row",  {30'd0, bus0.wr_row}, 32'd2);
    chk("mid_pre_gen",  {16'd0, gc0}, 32'd2);
    chk("mid_pre_data", {24'd0, bus0.wr_data}, 32'h05);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_en",   {31'd0, bus0.wr_en}, 32'd0);
    chk("async_rst_row",  {30'd0, bus0.wr_row}, 32'd0);
    chk("async_rst_gen",  {16'd0, gc0}, 32'd0);
    chk("async_rst_busy", {31'd0, busy0}, 32'd0);
    cyc(); rst = 1'b0; cyc();

    // Backpressure with tick and run held high
    rule = 8'd30; seed = 8'h10; load = 1'b1; cyc(); load = 1'b0;
    tick = 1'b1; run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("bp_hold", {22'd0, bus0.wr_en, bus0.wr_row, bus0.wr_data}, {22'd0, 1'b1, 2'd0, 8'h10});
    end
    tick = 1'b0; run = 1'b0;
    chk("bp_overrun", {31'd0, ov0}, 32'd1);
    ready = 1'b1; cyc();
    chk("bp_accept_en",  {31'd0, bus0.wr_en}, 32'd0);
    chk("bp_accept_row", {30'd0, bus0.wr_row}, 32'd1);
    cyc();
    chk("bp_single_write", {31'd0, bus0.wr_en}, 32'd0);
    chk("bp_gen", {16'd0, gc0}, 32'd0);
    load = 1'b1; cyc(); load = 1'b0;
    chk("bp_load_clears_ovr", {31'd0, ov0}, 32'd0);
    cyc();

    // Load and tick in the same WAIT cycle
    step = 1'b1; cyc(); step = 1'b0; cyc();
    chk("lt_pre_gen", {16'd0, gc0}, 32'd1);
    seed = 8'h5A; load = 1'b1; tick = 1'b1; run = 1'b1; cyc();
    load = 1'b0; tick = 1'b0; run = 1'b0;
    chk("lt_data", {24'd0, bus0.wr_data}, 32'h5A);
    chk("lt_row",  {30'd0, bus0.wr_row}, 32'd0);
    chk("lt_gen",  {16'd0, gc0}, 32'd0);
    chk("lt_ovr",  {31'd0, ov0}, 32'd0);
    cyc();

    // Frame wrap: five ticks after load with run high
    seed = 8'h10; rule = 8'd30; load = 1'b1; cyc(); load = 1'b0; cyc();
    run = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick = 1'b1; cyc(); tick = 1'b0;
      chk($sformatf("fr%0d_en", k),   {31'd0, bus0.wr_en}, 32'd1);
      chk($sformatf("fr%0d_data", k), {24'd0, bus0.wr_data}, {24'd0, exp_data[k]});
      chk($sformatf("fr%0d_row", k),  {30'd0, bus0.wr_row}, {30'd0, exp_row[k]});
      chk($sformatf("fr%0d_gen", k),  {16'd0, gc0}, {16'd0, exp_gen[k]});
      chk($sformatf("fr%0d_fd_lo", k), {31'd0, fd0}, 32'd0);
      cyc();
      chk($sformatf("fr%0d_fd", k),  {31'd0, fd0}, {31'd0, exp_fd[k]});
      chk($sformatf("fr%0d_top", k), {30'd0, top0}, {30'd0, exp_top[k]});
    end
    run = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
